// File: rtl/iot_bus_mux_pkg.sv
// iot_bus_mux_pkg: shared CPU state encodings, IOT instruction field positions and decode helpers.
//   Provides: ST_F2/ST_F3 major-state codes, IOT opcode/field bit positions,
//   function codes, iot_t decoded-instruction struct, decode() and is_eae_skip().
package iot_bus_mux_pkg;

    localparam logic [4:0] ST_F2 = 5'd2;
    localparam logic [4:0] ST_F3 = 5'd3;

    // Instruction is numbered [0:11] with bit 0 as MSB.
    localparam int OP_MSB  = 0;
    localparam int OP_LSB  = 2;
    localparam int DEV_MSB = 3;
    localparam int DEV_LSB = 8;
    localparam int FN_MSB  = 9;
    localparam int FN_LSB  = 11;

    localparam logic [2:0] OP_IOT  = 3'o6;
    localparam logic [2:0] FN_BUS4 = 3'o4;
    localparam logic [2:0] FN_LAC  = 3'o5;
    localparam logic [2:0] FN_BUS6 = 3'o6;

    typedef struct packed {
        logic       iot;
        logic [5:0] code;
        logic [2:0] fn;
    } iot_t;

    function automatic iot_t decode(input logic [0:11] ins);
        iot_t d;
        d.iot  = ins[OP_MSB:OP_LSB] == OP_IOT;
        d.code = ins[DEV_MSB:DEV_LSB];
        d.fn   = ins[FN_MSB:FN_LSB];
        return d;
    endfunction

    // EAE skip-class opcodes: 7671 plus 1111????{0011,0111,1011,1101,1111}.
    function automatic logic is_eae_skip(input logic [0:11] ins);
        logic [0:3] lo;
        lo = ins[8:11];
        return ins == 12'o7671 ||
               (ins[0:3] == 4'hF && (lo == 4'b0011 || lo == 4'b0111 ||
                                     lo == 4'b1011 || lo == 4'b1101 || lo == 4'b1111));
    endfunction

endpackage

// File: rtl/iot_bus_mux_irq_sync.sv
// irq_sync: two-flop synchroniser for asynchronous request lines.
//   clk, reset (sync, active-high); d[WIDTH] asynchronous in; q[WIDTH] synchronised out (2 clk latency).
module irq_sync
    import iot_bus_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q, sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/iot_bus_mux.sv
// iot_bus_mux: IOT device-channel decoder, data/skip mux, interrupt masking and front-panel bus capture.
//   In:  clk, reset (sync, active-high), state[5], instruction[0:11], ac[12],
//        dev_data[12*NUM_DEV], dev_skip[NUM_DEV], dev_irq[NUM_DEV] (async), EAE_skip.
//   Out: skip, in_bus[12], dev_sel[NUM_DEV] (combinational);
//        irq, irq_src[4], bus_display[12], iot_err (registered).
module iot_bus_mux
    import iot_bus_mux_pkg::*;
#(
    parameter int                    NUM_DEV   = 4,
    parameter logic [6*NUM_DEV-1:0]  DEV_CODES = {6'o20, 6'o04, 6'o03, 6'o00},
    parameter int                    EAE_EN    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             state,
    input  logic [0:11]            instruction,
    input  logic [11:0]            ac,
    input  logic [12*NUM_DEV-1:0]  dev_data,
    input  logic [NUM_DEV-1:0]     dev_skip,
    input  logic [NUM_DEV-1:0]     dev_irq,
    input  logic                   EAE_skip,
    output logic                   skip,
    output logic [11:0]            in_bus,
    output logic [NUM_DEV-1:0]     dev_sel,
    output logic                   irq,
    output logic [3:0]             irq_src,
    output logic [11:0]            bus_display,
    output logic                   iot_err
);

    iot_t               dec;
    logic [NUM_DEV-1:0] match, sync_irq, pending;
    logic               dev_skip_sel, f3_iot;

    logic [NUM_DEV-1:0] ie_d, ie_q;
    logic               irq_d, irq_q, iot_err_d, iot_err_q;
    logic [3:0]         irq_src_d, irq_src_q;
    logic [11:0]        lac_d, lac_q, lbus_d, lbus_q, bus_display_d, bus_display_q;

    assign dec = decode(instruction);

    // Shared codes resolve to the lowest-index channel.
    genvar i;
    for (i = 0; i < NUM_DEV; i++) begin : g_ch
        assign match[i] = dec.iot && dec.code == DEV_CODES[6*i +: 6];
        if (i == 0) begin : g_first
            assign dev_sel[i] = match[i];
        end else begin : g_rest
            assign dev_sel[i] = match[i] && !(|match[i-1:0]);
        end
    end

    always_comb begin
        in_bus       = '0;
        dev_skip_sel = 1'b0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (dev_sel[k]) begin
                in_bus       = dev_data[12*k +: 12];
                dev_skip_sel = dev_skip[k];
            end
        end
        skip = (EAE_EN != 0 && is_eae_skip(instruction)) ? EAE_skip : dev_skip_sel;
    end

    irq_sync #(.WIDTH(NUM_DEV)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dev_irq),
        .q     (sync_irq)
    );

    always_comb begin
        f3_iot    = state == ST_F3 && dec.iot;
        pending   = sync_irq & ie_q;
        irq_d     = |pending;
        irq_src_d = irq_src_q;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (pending[k]) irq_src_d = 4'(k);
        end
        ie_d = (state == ST_F3 && dec.fn == FN_LAC) ?
               (ie_q & ~dev_sel) | (dev_sel & {NUM_DEV{ac[11]}}) : ie_q;
        lac_d  = state == ST_F2 ? ac : lac_q;
        lbus_d = state == ST_F2 ? in_bus : lbus_q;
        bus_display_d = !f3_iot                                   ? bus_display_q :
                        (dec.fn == FN_BUS4 || dec.fn == FN_BUS6)  ? lbus_q :
                        dec.fn == FN_LAC                          ? lac_q : bus_display_q;
        iot_err_d = iot_err_q || (f3_iot && !(|dev_sel) && dec.code != 6'o00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q          <= '1;
            irq_q         <= 1'b0;
            irq_src_q     <= '0;
            lac_q         <= '0;
            lbus_q        <= '0;
            bus_display_q <= '0;
            iot_err_q     <= 1'b0;
        end else begin
            ie_q          <= ie_d;
            irq_q         <= irq_d;
            irq_src_q     <= irq_src_d;
            lac_q         <= lac_d;
            lbus_q        <= lbus_d;
            bus_display_q <= bus_display_d;
            iot_err_q     <= iot_err_d;
        end
    end

    assign irq         = irq_q;
    assign irq_src     = irq_src_q;
    assign bus_display = bus_display_q;
    assign iot_err     = iot_err_q;

endmodule

// File: doc/iot_bus_mux.md
IOT_BUS_MUX -- requirements
Module: iot_bus_mux

Interface
REQ-001 Parameter NUM_DEV, default 4: number of IOT device channels, 1..16.
REQ-002 Parameter DEV_CODES, default {6'o20,6'o04,6'o03,6'o00}: packed 6-bit device codes; channel i uses bits [6i+5:6i].
REQ-003 Parameter EAE_EN, default 1: 1 enables the EAE skip path.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 state  input  5  CPU major state; F2/F3 encodings come from the shared parameters file.
REQ-007 instruction  input  12  current instruction, bits [0:11], bit 0 MSB.
REQ-008 ac  input  12  accumulator.
REQ-009 dev_data  input  12*NUM_DEV  per-channel read data.
REQ-010 dev_skip  input  NUM_DEV  per-channel skip condition.
REQ-011 dev_irq  input  NUM_DEV  per-channel interrupt request; asynchronous to clk.
REQ-012 EAE_skip  input  1  EAE skip condition.
REQ-013 skip  output  1  skip to the CPU; combinational.
REQ-014 in_bus  output  12  data to the CPU; combinational.
REQ-015 dev_sel  output  NUM_DEV  one-hot selected channel; combinational.
REQ-016 irq  output  1  registered, masked OR of synchronised requests.
REQ-017 irq_src  output  4  registered index of the lowest pending enabled channel.
REQ-018 bus_display  output  12  registered front-panel bus value.
REQ-019 iot_err  output  1  registered sticky flag: an IOT matched no channel.

Function
REQ-020 IOT means instruction[0:2]==3'o6; device code is instruction[3:8]; function is instruction[9:11].
REQ-021 dev_sel[i] is 1 only when an IOT is present and its device code equals the code for channel i.
REQ-022 When two channels share a code, dev_sel shall go to the lowest index only.
REQ-023 in_bus is dev_data of the selected channel; otherwise in_bus is 12'o0000.
REQ-024 skip is dev_skip of the selected channel.
REQ-025 When EAE_EN=1, skip is EAE_skip for 7671 and for any opcode matching 1111????0011, 1111????0111, 1111????1011, 1111????1101 or 1111????1111.
REQ-026 skip is 0 in all other cases.
REQ-027 Each dev_irq bit passes through a 2-flop synchroniser; latency is 2 clk.
REQ-028 Mask register ie[NUM_DEV-1:0] is loaded on the clk where state==F3, dev_sel[i]=1 and function==3'o5: ie[i] <= ac[11]. Other bits hold.
REQ-029 irq <= |(sync_irq & ie).
REQ-030 irq_src <= lowest i with sync_irq[i]&ie[i]; holds its previous value when none is pending.
REQ-031 When state==F2, the block captures ac and in_bus into lac and lbus.
REQ-032 When state==F3 and an IOT is present, bus_display <= lbus for function 4 or 6, lac for function 5, and holds for other functions.
REQ-033 bus_display holds for all non-IOT instructions.
REQ-034 iot_err sets when state==F3, an IOT is present, no channel matches, and the device code is not 00; it clears only on reset.
REQ-035 If a mask load and a new request arrive on the same clk, the new ie value applies from the next clk.
REQ-036 A device code with no matching channel never produces a skip, even when dev_skip inputs are high.

Reset
REQ-037 Reset values: bus_display=0, lac=0, lbus=0, ie=all ones, synchroniser flops=0, irq=0, irq_src=0, iot_err=0.
REQ-038 Reset dominates every other update on the same clk, including reset asserted mid-instruction.
REQ-039 Combinational outputs are unaffected by reset.

Structure
REQ-040 State encodings F2/F3 and IOT field positions live in the shared parameters file; there are no local copies.
REQ-041 One sub-module, irq_sync, is a 2-flop synchroniser of parameter width, instantiated once with width NUM_DEV.
REQ-042 Channel decode uses a generate loop; there is no per-channel hand-written code.

Verification
REQ-043 Instruction 6034 with channel 1 code 03, dev_data[1]=12'o0215, dev_skip[1]=1 -> in_bus=0215, skip=1, dev_sel=4'b0010.
REQ-044 Instruction 6036 through F2 then F3 with dev_data[1]=12'o0301 -> bus_display=0301 on the clk after F3.
REQ-045 dev_irq[2] rises -> irq=1 and irq_src=2 on the 3rd clk; then 6045 at F3 with ac=0 (channel 2 code 04) -> irq=0 after 1 clk.
REQ-046 dev_irq=4'b1010 with ie all ones -> irq_src=1; then clear ie[1] -> irq_src=3.
REQ-047 Instruction 6554 at F3 -> iot_err=1, and it holds until reset.
REQ-048 Instruction 7413 with EAE_skip=1 -> skip=1; with EAE_EN=0 -> skip=0. Reset during F3 of 6005 -> bus_display=0.
